// File: rtl/beeper_unit_if.sv
// ============================================================================
// Module      : beeper_unit_if
// Description : Peripheral write-strobe bus and status outputs of the beeper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface beeper_unit_if;
    logic       wrStrobe;
    logic [1:0] regSel;
    logic [7:0] dataIn;
    logic       beeper;
    logic       busy;
    logic [7:0] remaining;
    logic       pendingValid;

    modport master (
        output wrStrobe, regSel, dataIn,
        input  beeper, busy, remaining, pendingValid
    );

    modport slave (
        input  wrStrobe, regSel, dataIn,
        output beeper, busy, remaining, pendingValid
    );
endinterface

`default_nettype wire

// File: rtl/beeper_unit.sv
// ============================================================================
// Module      : beeper_unit
// Description : Memory-mapped sound timer and square-wave tone generator.
//               Define BEEPER_QUEUE_EN for a one-deep queued duration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module beeper_unit #(
    parameter int TICK_DIV  = 166667,
    parameter int TONE_BASE = 64
) (
    input  wire logic     clk,
    input  wire logic     rst,
    beeper_unit_if.slave  bus
);

    localparam int c_TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int c_H_RAW  = $clog2(TONE_BASE + 1) + 9;
    localparam int c_H_W    = (c_H_RAW > 17) ? c_H_RAW : 17;

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_PLAY = 1'b1;

    localparam logic [1:0] c_REG_PITCH = 2'd0;
    localparam logic [1:0] c_REG_DUR   = 2'd1;
    localparam logic [1:0] c_REG_CTRL  = 2'd2;

    logic [0:0]          r_state;
    logic [7:0]          r_pitch;
    logic                r_mute;
    logic [7:0]          r_remaining;
    logic [c_TICK_W-1:0] r_tick;
    logic [c_H_W-1:0]    r_tone;
    logic [c_H_W-1:0]    r_half;
    logic                r_tone_bit;

    logic                w_play;
    logic                w_wr_pitch;
    logic                w_wr_dur;
    logic                w_wr_ctrl;
    logic                w_dur_nz;
    logic                w_stop;
    logic                w_tick_wrap;
    logic                w_tone_wrap;
    logic                w_expire;
    logic [c_H_W-1:0]    w_half;

    assign w_play      = (r_state == c_PLAY);
    assign w_wr_pitch  = bus.wrStrobe && (bus.regSel == c_REG_PITCH);
    assign w_wr_dur    = bus.wrStrobe && (bus.regSel == c_REG_DUR);
    assign w_wr_ctrl   = bus.wrStrobe && (bus.regSel == c_REG_CTRL);
    assign w_dur_nz    = (bus.dataIn != 8'd0);
    // A zero-duration write during a tone behaves exactly like the stop bit.
    assign w_stop      = w_play && ((w_wr_ctrl && bus.dataIn[1]) || (w_wr_dur && !w_dur_nz));
    assign w_tick_wrap = w_play && (r_tick == c_TICK_W'(TICK_DIV - 1));
    assign w_tone_wrap = (r_tone == (r_half - c_H_W'(1)));
    assign w_expire    = w_tick_wrap && (r_remaining == 8'd1);
    assign w_half      = (c_H_W'(r_pitch) + c_H_W'(1)) * c_H_W'(TONE_BASE);

    assign bus.busy      = w_play;
    assign bus.beeper    = r_tone_bit && !r_mute && w_play;
    assign bus.remaining = r_remaining;

`ifdef BEEPER_QUEUE_EN
    logic [7:0] r_pending;
    logic       r_pending_valid;
    assign bus.pendingValid = r_pending_valid;
`else
    assign bus.pendingValid = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_pitch     <= 8'd0;
            r_mute      <= 1'b0;
            r_remaining <= 8'd0;
            r_tick      <= '0;
            r_tone      <= '0;
            r_half      <= '0;
            r_tone_bit  <= 1'b0;
`ifdef BEEPER_QUEUE_EN
            r_pending       <= 8'd0;
            r_pending_valid <= 1'b0;
`endif
        end else begin
            if (w_wr_pitch) begin
                r_pitch <= bus.dataIn;
            end
            if (w_wr_ctrl) begin
                r_mute <= bus.dataIn[0];
            end

            case (r_state)
                c_IDLE: begin
                    if (w_wr_dur && w_dur_nz) begin
                        r_state     <= c_PLAY;
                        r_remaining <= bus.dataIn;
                        r_tick      <= '0;
                        r_tone      <= '0;
                        r_tone_bit  <= 1'b0;
                        r_half      <= w_half;
                    end
                end

                c_PLAY: begin
                    // Shadow half-period only reloads at a wrap so an edge is never cut short.
                    if (w_tone_wrap) begin
                        r_tone     <= '0;
                        r_tone_bit <= !r_tone_bit;
                        r_half     <= w_half;
                    end else begin
                        r_tone <= r_tone + c_H_W'(1);
                    end

                    if (w_tick_wrap) begin
                        r_tick      <= '0;
                        r_remaining <= r_remaining - 8'd1;
                    end else begin
                        r_tick <= r_tick + c_TICK_W'(1);
                    end

                    if (w_stop) begin
                        r_state     <= c_IDLE;
                        r_remaining <= 8'd0;
                        r_tick      <= '0;
                        r_tone      <= '0;
                        r_tone_bit  <= 1'b0;
`ifdef BEEPER_QUEUE_EN
                        r_pending_valid <= 1'b0;
`endif
                    end else if (w_wr_dur) begin
`ifdef BEEPER_QUEUE_EN
                        // Landing on expiry, the new duration is consumed at once instead of queued.
                        if (w_expire) begin
                            r_remaining     <= bus.dataIn;
                            r_pending_valid <= 1'b0;
                        end else begin
                            r_pending       <= bus.dataIn;
                            r_pending_valid <= 1'b1;
                        end
`else
                        r_remaining <= bus.dataIn;
                        r_tick      <= '0;
                        r_tone      <= '0;
                        r_tone_bit  <= 1'b0;
                        r_half      <= w_half;
`endif
                    end else if (w_expire) begin
`ifdef BEEPER_QUEUE_EN
                        if (r_pending_valid) begin
                            r_remaining     <= r_pending;
                            r_pending_valid <= 1'b0;
                        end else begin
                            r_state     <= c_IDLE;
                            r_remaining <= 8'd0;
                            r_tone      <= '0;
                            r_tone_bit  <= 1'b0;
                        end
`else
                        r_state     <= c_IDLE;
                        r_remaining <= 8'd0;
                        r_tone      <= '0;
                        r_tone_bit  <= 1'b0;
`endif
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_beeper_unit.sv
// ============================================================================
// Module      : tb_beeper_unit
// Description : Directed self-checking bench for beeper_unit (TICK_DIV=10,
//               TONE_BASE=2); honours BEEPER_QUEUE_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_beeper_unit;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    beeper_unit_if bif ();

    beeper_unit #(
        .TICK_DIV  (10),
        .TONE_BASE (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the strobe is seen by exactly one posedge.
    task automatic wr(input logic [1:0] sel, input logic [7:0] d);
        bif.wrStrobe = 1'b1;
        bif.regSel   = sel;
        bif.dataIn   = d;
        @(negedge clk);
        bif.wrStrobe = 1'b0;
        bif.regSel   = 2'd0;
        bif.dataIn   = 8'd0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, bif.busy, 0);
        chk({tag, "_rem"},  bif.remaining, 0);
        chk({tag, "_beep"}, bif.beeper, 0);
        chk({tag, "_pv"},   bif.pendingValid, 0);
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        bif.wrStrobe = 1'b0;
        bif.regSel   = 2'd0;
        bif.dataIn   = 8'd0;
        step(3);
        rst = 1'b0;
        step(1);
        chk_idle("reset");

        // Basic tone: H=4, 3 ticks of 10 clocks.
        wr(2'd0, 8'd1);
        wr(2'd1, 8'd3);
        for (int k = 0; k < 30; k++) begin
            chk("t1_busy", bif.busy, 1);
            chk("t1_rem",  bif.remaining, 3 - k / 10);
            chk("t1_beep", bif.beeper, (k / 4) % 2);
            step(1);
        end
        chk_idle("t1_end");

        // Mute then unmute keeps the phase; stop bit ends the tone.
        wr(2'd1, 8'd3);
        step(5);
        chk("t2_pre_beep", bif.beeper, 1);
        wr(2'd2, 8'h01);
        chk("t2_mute_beep", bif.beeper, 0);
        chk("t2_mute_rem",  bif.remaining, 3);
        step(6);
        chk("t2_mute_beep12", bif.beeper, 0);
        chk("t2_mute_rem12",  bif.remaining, 2);
        wr(2'd2, 8'h00);
        chk("t2_unmute_beep13", bif.beeper, 1);
        step(3);
        chk("t2_unmute_beep16", bif.beeper, 0);
        wr(2'd3, 8'h02);
        chk("t2_rsv_busy", bif.busy, 1);
        chk("t2_rsv_rem",  bif.remaining, 2);
        wr(2'd2, 8'h02);
        chk_idle("t2_stop");
        wr(2'd1, 8'd0);
        chk_idle("t2_zero_idle");

        // Pitch 3 -> 0 mid tone: the 8-clock half-period completes first.
        wr(2'd0, 8'd3);
        wr(2'd1, 8'd9);
        step(3);
        wr(2'd0, 8'd0);
        step(3);
        chk("t3_beep7", bif.beeper, 0);
        step(1);
        chk("t3_beep8", bif.beeper, 1);
        step(1);
        chk("t3_beep9", bif.beeper, 1);
        step(1);
        chk("t3_beep10", bif.beeper, 0);
        step(2);
        chk("t3_beep12", bif.beeper, 1);
        wr(2'd1, 8'd0);
        chk_idle("t3_zero_stop");

        // Second duration write 12 clocks into a 3-tick tone.
        wr(2'd0, 8'd1);
        wr(2'd1, 8'd3);
        step(11);
        wr(2'd1, 8'd5);
`ifdef BEEPER_QUEUE_EN
        chk("t4q_pv",   bif.pendingValid, 1);
        chk("t4q_rem",  bif.remaining, 2);
        chk("t4q_beep", bif.beeper, 1);
        step(17);
        chk("t4q_rem29", bif.remaining, 1);
        chk("t4q_pv29",  bif.pendingValid, 1);
        step(1);
        chk("t4q_busy30", bif.busy, 1);
        chk("t4q_rem30",  bif.remaining, 5);
        chk("t4q_pv30",   bif.pendingValid, 0);
        step(49);
        chk("t4q_busy79", bif.busy, 1);
        step(1);
        chk_idle("t4q_end80");
`else
        chk("t4_pv",   bif.pendingValid, 0);
        chk("t4_rem",  bif.remaining, 5);
        chk("t4_beep12", bif.beeper, 0);
        step(3);
        chk("t4_beep15", bif.beeper, 0);
        step(1);
        chk("t4_beep16", bif.beeper, 1);
        step(45);
        chk("t4_busy61", bif.busy, 1);
        chk("t4_rem61",  bif.remaining, 1);
        step(1);
        chk_idle("t4_end62");
`endif

        // Reset mid tone, then a clean 2-tick tone with pitch back at 0.
        wr(2'd1, 8'd3);
        step(5);
        rst = 1'b1;
        step(1);
        chk_idle("t5_rst");
        rst = 1'b0;
        wr(2'd1, 8'd2);
        chk("t5_busy0", bif.busy, 1);
        chk("t5_rem0",  bif.remaining, 2);
        step(2);
        chk("t5_beep2", bif.beeper, 1);
        step(17);
        chk("t5_busy19", bif.busy, 1);
        chk("t5_rem19",  bif.remaining, 1);
        step(1);
        chk_idle("t5_end20");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/beeper_unit.md
Name: beeper_unit

Overview:
- Memory-mapped sound timer and tone generator that drives the board beeper.
- Sits directly downstream of the IO memory/port decoder and consumes its peripheral write strobes (register select plus data byte).
- A duration write starts a square-wave tone. Duration counts down at a fixed tick rate (60 Hz at the target clock). Pitch and mute are software controlled.

Parameters:
- TICK_DIV, 166667: clocks per duration tick (10 MHz / 60). Minimum 2.
- TONE_BASE, 64: clocks per pitch unit. Tone half-period H = (pitch+1)*TONE_BASE clocks.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- wrStrobe  input  1  one-cycle register write from the IO decoder.
- regSel  input  2  register select: 0 = PITCH, 1 = DURATION (start), 2 = CTRL, 3 = reserved (write ignored).
- dataIn  input  8  write data (dataBusIn).
- beeper  output  1  square-wave tone to the speaker.
- busy  output  1  high while a tone is active.
- remaining  output  8  ticks left in the current tone.
- pendingValid  output  1  a queued duration is waiting (feature only).

Behaviour:
- Reset: beeper=0, busy=0, remaining=0, pendingValid=0, pitch=0, mute=0, state IDLE, all counters 0. Reset overrides any in-flight tone.
- States:
  - IDLE: busy=0, beeper=0.
  - PLAY: busy=1.
- PITCH write: pitch register <= dataIn.
  - The active half-period is a shadow copy, reloaded on entering PLAY and at each tone-counter wrap.
  - A mid-tone pitch change therefore takes effect at the next edge, never mid-half-period.
- DURATION write, value D, strobe sampled at edge N:
  - IDLE, D!=0: at N+1 enter PLAY, busy=1, remaining=D, tick counter=0, tone counter=0, beeper=0, shadow half-period loaded from pitch.
  - IDLE, D=0: no effect.
  - PLAY, D!=0 (feature off): restart exactly as from IDLE with the new D; tone phase is reset.
  - PLAY, D=0: stop. IDLE at N+1, remaining=0, beeper=0.
- CTRL write:
  - bit0 = mute: beeper forced 0; counters keep running.
  - bit1 = stop (self-clearing, not stored): PLAY->IDLE at N+1, remaining=0. Ignored in IDLE.
  - Other bits are ignored.
- Tick counter runs 0..TICK_DIV-1 in PLAY only.
  - At each wrap, remaining decrements.
  - A wrap with remaining==1 gives remaining=0 and IDLE next cycle.
  - Total tone length is exactly D*TICK_DIV clocks from busy rising to busy falling.
- Tone counter runs 0..H-1 in PLAY.
  - At each wrap the internal tone bit toggles.
  - beeper = toneBit & ~mute & busy.
  - First rising edge occurs H clocks after PLAY entry.
- Width rules:
  - H is computed at least 17 bits wide; no overflow for pitch=255 with TONE_BASE up to 256.
  - The tick counter is sized with $clog2(TICK_DIV).
- Simultaneous events:
  - Natural expiry and a DURATION write in the same cycle: the write wins (restart, or queue when the feature is enabled).
  - Natural expiry and stop in the same cycle: IDLE.
- regSel=3 writes are ignored.
- No read path; software polls through remaining/busy, which the IO decoder maps.

Optional Feature:
- Macro: BEEPER_QUEUE_EN.
- Enabled:
  - A nonzero DURATION write during PLAY stores into a one-deep pending register and sets pendingValid=1. A later write overwrites it.
  - At natural expiry with pendingValid: remaining <= pending, tick counter=0, stay PLAY (no idle cycle, busy stays 1, tone phase continues), pendingValid=0.
  - Stop, a D=0 write, or reset clear pendingValid.
- Disabled: pendingValid tied 0; a write during PLAY restarts immediately.

Test Plan (TICK_DIV=10, TONE_BASE=2):
- Reset, then PITCH=1, DURATION=3 -> busy rises one cycle after the strobe and stays high exactly 30 clocks. remaining steps 3,2,1,0. beeper toggles every 4 clocks starting low, first high at clock 4.
- During play, CTRL=0x01 -> beeper held 0 while remaining keeps counting. CTRL=0x00 -> toggling resumes in phase.
- During play, CTRL=0x02 -> busy=0, remaining=0, beeper=0 next cycle. DURATION=0 while idle -> no change.
- PITCH=0 written mid-tone with PITCH=3 active -> current 8-clock half-period completes, subsequent half-periods are 2 clocks.
- Feature off: DURATION=5 after 12 clocks of a DURATION=3 tone -> remaining=5 next cycle, total busy=12+50 clocks. Feature on: same stimulus -> pendingValid=1, busy continuous for 30+50 clocks, pendingValid falls at the first expiry.
- rst asserted mid-tone -> all outputs 0 the next cycle. A DURATION=2 write after reset release plays normally for 20 clocks.
